id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register with operand-forwarding muxes for the RV32I 5-stage pipeline.
- Consumes the 3-bit rs1/rs2 forwarding choice codes from the decode-stage hazard detector and selects each source operand from the register file, EX, MEM or WB.
- Detects load-use hazards and inserts one bubble per hazard cycle.
- Registers the decoded instruction into EX under a valid/ready handshake, with flush for branch redirects.

Parameters:
- XLEN, 32, datapath width.
- CTRL_W, 16, width of opaque decoded-control bundle passed to EX.
- CNT_W, 32, width of load-use stall performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode stage holds a valid instruction.
- id_ready  out  1  stage accepts the ID instruction this cycle.
- id_pc  in  XLEN  instruction PC.
- id_imm  in  XLEN  decoded immediate.
- id_rd  in  5  destination register.
- id_ctrl  in  CTRL_W  decoded control bundle.
- id_rs1_used  in  1  instruction reads rs1.
- id_rs2_used  in  1  instruction reads rs2.
- rs1_choice  in  3  forwarding select for rs1 from the hazard detector.
- rs2_choice  in  3  forwarding select for rs2 from the hazard detector.
- rf_rdata1  in  XLEN  register-file read data for rs1.
- rf_rdata2  in  XLEN  register-file read data for rs2.
- exu_fwd_data  in  XLEN  EX-stage ALU result.
- exu_mem_ren  in  1  instruction in EX is a load.
- mem_alu_data  in  XLEN  MEM-stage ALU result.
- mem_load_data  in  XLEN  MEM-stage load data.
- wb_data  in  XLEN  WB-stage write data.
- flush  in  1  branch/jump redirect; kill ID and EX contents.
- ex_ready  in  1  EX stage can accept a new instruction.
- ex_valid  out  1  registered instruction valid to EX.
- ex_pc  out  XLEN  registered PC.
- ex_src1  out  XLEN  registered forwarded rs1 operand.
- ex_src2  out  XLEN  registered forwarded rs2 operand.
- ex_imm  out  XLEN  registered immediate.
- ex_rd  out  5  registered rd.
- ex_ctrl  out  CTRL_W  registered control bundle.
- luse_stall_cnt  out  CNT_W  count of load-use bubble cycles.

Behaviour:
- Reset (rst_n low, asynchronous): ex_valid=0; ex_pc, ex_src1, ex_src2, ex_imm=0; ex_rd=0; ex_ctrl=0; luse_stall_cnt=0.
- Choice decode, per operand, combinational:
  - 000 selects rf_rdata.
  - 001 selects exu_fwd_data.
  - 010 selects mem_alu_data.
  - 011 selects mem_load_data.
  - 100 selects wb_data.
  - 101–111 select rf_rdata.
- load_use = id_valid & exu_mem_ren & ((id_rs1_used & rs1_choice==001) | (id_rs2_used & rs2_choice==001)).
- id_ready = ~load_use & (~ex_valid | ex_ready). Purely combinational; no dependency on id_valid except through load_use.
- fire = id_valid & id_ready.
- Register update, priority order:
  - flush: ex_valid<=0; payload don't-care (held); no stall count.
  - else if (~ex_valid | ex_ready): ex_valid<=fire. On fire, all payload captured in the same edge (latency 1 cycle ID→EX). On a load_use bubble, ex_valid<=0 and payload holds.
  - else (EX backpressured): all outputs hold.
- Stall counter: increments by 1 on each cycle with load_use & ~flush & (~ex_valid | ex_ready). Saturates at all-ones; no wrap.
- Load-use resolves naturally: the next cycle the load is in MEM, the detector reports 011 and fire proceeds. Exactly one bubble per load-use pair when ex_ready=1.
- Simultaneous flush and load_use: flush wins; counter unchanged; id_ready still 0 (upstream also flushed).
- Simultaneous flush and fire: ex_valid<=0; instruction discarded.
- rs=x0: the detector already yields 000; the stage does not special-case it.
- Reset mid-operation: all state cleared immediately; first accept possible on the first rising edge after rst_n rises.

Decomposition:
- Shared package (riscv_pipe_pkg):
  - localparams FWD_RF=3'b000, FWD_EXU=3'b001, FWD_MEM_ALU=3'b010, FWD_MEM_LD=3'b011, FWD_WB=3'b100.
  - XLEN.
  - typedef of the ID→EX payload struct (pc, src1, src2, imm, rd, ctrl).
- Sub-module: fwd_mux, a combinational 5:1 operand selector instantiated twice (rs1, rs2).
- Register, handshake and counter logic stay in the top.

Test Plan:
- Plain forward: rs1_choice=000, rs2_choice=010, rf_rdata1=0x11, mem_alu_data=0x22, ex_ready=1, id_valid=1 → next cycle ex_valid=1, ex_src1=0x11, ex_src2=0x22.
- All codes: sweep rs1_choice 000..111 with distinct source values 0xA0..0xA4 → ex_src1 equals the selected source; codes 101–111 give rf_rdata1.
- Load-use: exu_mem_ren=1, rs1_choice=001, id_rs1_used=1 → id_ready=0, ex_valid=0 next cycle, luse_stall_cnt=1. Following cycle rs1_choice=011, mem_load_data=0xDEAD → fire, ex_src1=0xDEAD.
- False-stall check: same as load-use but id_rs1_used=0 → id_ready=1, no bubble, counter stays 0.
- Backpressure: ex_valid=1, ex_ready=0 for 3 cycles with new ID data → id_ready=0, outputs hold original values; ex_ready=1 → new instruction captured next edge.
- Flush and reset: flush=1 with fire and load_use asserted → ex_valid=0, counter unchanged; async rst_n pulse mid-cycle → ex_valid and luse_stall_cnt 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the RV32I 5-stage pipeline.
//   - Forwarding choice codes produced by the decode-stage hazard detector.
//   - XLEN / CTRL_W defaults.
//   - id_ex_payload_t: the instruction payload registered from ID into EX.
package riscv_pipe_pkg;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 16;

    localparam logic [2:0] FWD_RF      = 3'b000;
    localparam logic [2:0] FWD_EXU     = 3'b001;
    localparam logic [2:0] FWD_MEM_ALU = 3'b010;
    localparam logic [2:0] FWD_MEM_LD  = 3'b011;
    localparam logic [2:0] FWD_WB      = 3'b100;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   src1;
        logic [XLEN-1:0]   src2;
        logic [XLEN-1:0]   imm;
        logic [4:0]        rd;
        logic [CTRL_W-1:0] ctrl;
    } id_ex_payload_t;

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// fwd_mux: combinational 5:1 operand selector driven by a forwarding choice code.
// Ports:
//   sel_i      forwarding choice (FWD_* codes); unused codes 101..111 pick rf_i
//   rf_i       register-file read data
//   exu_i      EX-stage ALU result
//   mem_alu_i  MEM-stage ALU result
//   mem_ld_i   MEM-stage load data
//   wb_i       WB-stage write data
//   y_o        selected operand
module fwd_mux
    import riscv_pipe_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [2:0]   sel_i,
    input  logic [W-1:0] rf_i,
    input  logic [W-1:0] exu_i,
    input  logic [W-1:0] mem_alu_i,
    input  logic [W-1:0] mem_ld_i,
    input  logic [W-1:0] wb_i,
    output logic [W-1:0] y_o
);

    always_comb begin
        y_o = rf_i;
        case (sel_i)
            FWD_EXU:     y_o = exu_i;
            FWD_MEM_ALU: y_o = mem_alu_i;
            FWD_MEM_LD:  y_o = mem_ld_i;
            FWD_WB:      y_o = wb_i;
            default:     y_o = rf_i;
        endcase
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register with operand forwarding,
// load-use bubble insertion, branch flush and a load-use stall counter.
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   id_valid / id_ready        ID->stage handshake
//   id_pc, id_imm, id_rd, id_ctrl, id_rs1_used, id_rs2_used   decoded instruction
//   rs1_choice, rs2_choice     forwarding codes from the hazard detector
//   rf_rdata1/2, exu_fwd_data, mem_alu_data, mem_load_data, wb_data  operand sources
//   exu_mem_ren                instruction currently in EX is a load
//   flush                      branch/jump redirect, kills the EX slot
//   ex_ready / ex_valid        stage->EX handshake
//   ex_pc, ex_src1, ex_src2, ex_imm, ex_rd, ex_ctrl   registered payload
//   luse_stall_cnt             saturating count of load-use bubble cycles
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. id_ready is purely combinational from ex_valid, ex_ready and the
// load-use condition; it never depends on id_valid except through load_use.
// ex_valid/payload hold while ex_valid=1 and ex_ready=0.
module id_ex_operand_stage #(
    parameter int XLEN   = riscv_pipe_pkg::XLEN,
    parameter int CTRL_W = riscv_pipe_pkg::CTRL_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [4:0]        id_rd,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [2:0]        rs1_choice,
    input  logic [2:0]        rs2_choice,
    input  logic [XLEN-1:0]   rf_rdata1,
    input  logic [XLEN-1:0]   rf_rdata2,
    input  logic [XLEN-1:0]   exu_fwd_data,
    input  logic              exu_mem_ren,
    input  logic [XLEN-1:0]   mem_alu_data,
    input  logic [XLEN-1:0]   mem_load_data,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_src1,
    output logic [XLEN-1:0]   ex_src2,
    output logic [XLEN-1:0]   ex_imm,
    output logic [4:0]        ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  luse_stall_cnt
);

    riscv_pipe_pkg::id_ex_payload_t payload_q, payload_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [XLEN-1:0] src1_sel, src2_sel;
    logic            load_use;
    logic            slot_free;
    logic            fire;

    fwd_mux #(.W(XLEN)) u_fwd_rs1 (
        .sel_i     (rs1_choice),
        .rf_i      (rf_rdata1),
        .exu_i     (exu_fwd_data),
        .mem_alu_i (mem_alu_data),
        .mem_ld_i  (mem_load_data),
        .wb_i      (wb_data),
        .y_o       (src1_sel)
    );

    fwd_mux #(.W(XLEN)) u_fwd_rs2 (
        .sel_i     (rs2_choice),
        .rf_i      (rf_rdata2),
        .exu_i     (exu_fwd_data),
        .mem_alu_i (mem_alu_data),
        .mem_ld_i  (mem_load_data),
        .wb_i      (wb_data),
        .y_o       (src2_sel)
    );

    // A load in EX cannot forward its data yet; a consumer asking for the EX
    // result must wait one cycle until the load reaches MEM.
    assign load_use = id_valid & exu_mem_ren &
                      ((id_rs1_used & (rs1_choice == riscv_pipe_pkg::FWD_EXU)) |
                       (id_rs2_used & (rs2_choice == riscv_pipe_pkg::FWD_EXU)));

    assign slot_free = ~valid_q | ex_ready;
    assign id_ready  = ~load_use & slot_free;
    assign fire      = id_valid & id_ready;

    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        cnt_d     = cnt_q;
        if (flush) begin
            // Redirect kills the slot; payload is left as-is.
            valid_d = 1'b0;
        end else if (slot_free) begin
            valid_d = fire;
            if (fire) begin
                payload_d.pc   = id_pc;
                payload_d.src1 = src1_sel;
                payload_d.src2 = src2_sel;
                payload_d.imm  = id_imm;
                payload_d.rd   = id_rd;
                payload_d.ctrl = id_ctrl;
            end
            if (load_use && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ex_valid       = valid_q;
    assign ex_pc          = payload_q.pc;
    assign ex_src1        = payload_q.src1;
    assign ex_src2        = payload_q.src2;
    assign ex_imm         = payload_q.imm;
    assign ex_rd          = payload_q.rd;
    assign ex_ctrl        = payload_q.ctrl;
    assign luse_stall_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
module tb_id_ex_operand_stage;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc, id_imm;
    logic [4:0]  id_rd;
    logic [15:0] id_ctrl;
    logic        id_rs1_used, id_rs2_used;
    logic [2:0]  rs1_choice, rs2_choice;
    logic [31:0] rf_rdata1, rf_rdata2, exu_fwd_data, mem_alu_data, mem_load_data, wb_data;
    logic        exu_mem_ren;
    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_src1, ex_src2, ex_imm;
    logic [4:0]  ex_rd;
    logic [15:0] ex_ctrl;
    logic [31:0] luse_stall_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model state: what EX should be holding.
    logic        m_valid;
    logic [31:0] m_pc, m_src1, m_src2, m_imm;
    logic [4:0]  m_rd;
    logic [15:0] m_ctrl;
    longint      m_cnt;

    id_ex_operand_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_imm         (id_imm),
        .id_rd          (id_rd),
        .id_ctrl        (id_ctrl),
        .id_rs1_used    (id_rs1_used),
        .id_rs2_used    (id_rs2_used),
        .rs1_choice     (rs1_choice),
        .rs2_choice     (rs2_choice),
        .rf_rdata1      (rf_rdata1),
        .rf_rdata2      (rf_rdata2),
        .exu_fwd_data   (exu_fwd_data),
        .exu_mem_ren    (exu_mem_ren),
        .mem_alu_data   (mem_alu_data),
        .mem_load_data  (mem_load_data),
        .wb_data        (wb_data),
        .flush          (flush),
        .ex_ready       (ex_ready),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_src1        (ex_src1),
        .ex_src2        (ex_src2),
        .ex_imm         (ex_imm),
        .ex_rd          (ex_rd),
        .ex_ctrl        (ex_ctrl),
        .luse_stall_cnt (luse_stall_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Source code -> value: codes 0..4 index the five sources, others fall back to RF.
    function automatic logic [31:0] pick(input logic [2:0] c, input logic [31:0] rf,
                                         input logic [31:0] ex, input logic [31:0] ma,
                                         input logic [31:0] ml, input logic [31:0] wb);
        logic [31:0] src[5];
        src = '{rf, ex, ma, ml, wb};
        return (c <= 3'd4) ? src[c] : rf;
    endfunction

    function automatic logic model_load_use();
        return id_valid && exu_mem_ren &&
               ((id_rs1_used && rs1_choice == 3'd1) || (id_rs2_used && rs2_choice == 3'd1));
    endfunction

    function automatic logic model_ready();
        return !model_load_use() && (!m_valid || ex_ready);
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_pc = '0; m_src1 = '0; m_src2 = '0; m_imm = '0; m_rd = '0; m_ctrl = '0;
        m_cnt = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_ex_valid"}, 64'(ex_valid), 64'(m_valid));
        check({tag, "_cnt"}, 64'(luse_stall_cnt), 64'(m_cnt));
        if (m_valid) begin
            check({tag, "_ex_pc"},   64'(ex_pc),   64'(m_pc));
            check({tag, "_ex_src1"}, 64'(ex_src1), 64'(m_src1));
            check({tag, "_ex_src2"}, 64'(ex_src2), 64'(m_src2));
            check({tag, "_ex_imm"},  64'(ex_imm),  64'(m_imm));
            check({tag, "_ex_rd"},   64'(ex_rd),   64'(m_rd));
            check({tag, "_ex_ctrl"}, 64'(ex_ctrl), 64'(m_ctrl));
        end
    endtask

    // One clock: inputs are already driven. Checks id_ready before the edge,
    // advances the model on the edge, checks registered outputs after it.
    task automatic cycle(input string tag);
        logic lu, rdy, take;
        #1;
        lu   = model_load_use();
        rdy  = model_ready();
        take = id_valid && rdy;
        check({tag, "_id_ready"}, 64'(id_ready), 64'(rdy));
        @(posedge clk);
        #1;
        if (flush) begin
            m_valid = 1'b0;
        end else if (!m_valid || ex_ready) begin
            m_valid = take;
            if (take) begin
                m_pc   = id_pc;
                m_imm  = id_imm;
                m_rd   = id_rd;
                m_ctrl = id_ctrl;
                m_src1 = pick(rs1_choice, rf_rdata1, exu_fwd_data, mem_alu_data, mem_load_data, wb_data);
                m_src2 = pick(rs2_choice, rf_rdata2, exu_fwd_data, mem_alu_data, mem_load_data, wb_data);
            end
            if (lu && m_cnt < 64'hFFFF_FFFF) m_cnt++;
        end
        check_outputs(tag);
    endtask

    // ---------------- drivers ----------------
    task automatic drive_idle();
        id_valid = 0; id_pc = '0; id_imm = '0; id_rd = '0; id_ctrl = '0;
        id_rs1_used = 0; id_rs2_used = 0; rs1_choice = '0; rs2_choice = '0;
        rf_rdata1 = '0; rf_rdata2 = '0; exu_fwd_data = '0; exu_mem_ren = 0;
        mem_alu_data = '0; mem_load_data = '0; wb_data = '0;
        flush = 0; ex_ready = 1;
    endtask

    task automatic drive_instr(input logic [31:0] pc);
        id_valid = 1; id_pc = pc; id_imm = pc ^ 32'h0F0F_0000; id_rd = pc[4:0];
        id_ctrl = pc[15:0] ^ 16'h5A5A;
    endtask

    task automatic drive_rand();
        id_valid      = ($urandom_range(0, 3) != 0);
        id_pc         = $urandom;
        id_imm        = $urandom;
        id_rd         = 5'($urandom_range(0, 31));
        id_ctrl       = 16'($urandom);
        id_rs1_used   = 1'($urandom_range(0, 1));
        id_rs2_used   = 1'($urandom_range(0, 1));
        rs1_choice    = 3'($urandom_range(0, 7));
        rs2_choice    = 3'($urandom_range(0, 7));
        rf_rdata1     = $urandom;
        rf_rdata2     = $urandom;
        exu_fwd_data  = $urandom;
        exu_mem_ren   = ($urandom_range(0, 2) == 0);
        mem_alu_data  = $urandom;
        mem_load_data = $urandom;
        wb_data       = $urandom;
        flush         = ($urandom_range(0, 9) == 0);
        ex_ready      = ($urandom_range(0, 3) != 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0]  c1;
        logic [31:0] exp_src1;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [31:0] held_pc;
        logic [31:0] cnt_before;

        tbl[0] = '{3'b000, 32'hA0};
        tbl[1] = '{3'b001, 32'hA1};
        tbl[2] = '{3'b010, 32'hA2};
        tbl[3] = '{3'b011, 32'hA3};
        tbl[4] = '{3'b100, 32'hA4};
        tbl[5] = '{3'b101, 32'hA0};
        tbl[6] = '{3'b110, 32'hA0};
        tbl[7] = '{3'b111, 32'hA0};

        // ---- reset ----
        rst_n = 0;
        drive_idle();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        check("rst_ex_valid", 64'(ex_valid), 64'd0);
        check("rst_ex_pc",    64'(ex_pc),    64'd0);
        check("rst_ex_src1",  64'(ex_src1),  64'd0);
        check("rst_ex_src2",  64'(ex_src2),  64'd0);
        check("rst_ex_imm",   64'(ex_imm),   64'd0);
        check("rst_ex_rd",    64'(ex_rd),    64'd0);
        check("rst_ex_ctrl",  64'(ex_ctrl),  64'd0);
        check("rst_cnt",      64'(luse_stall_cnt), 64'd0);

        // ---- plain forward ----
        drive_instr(32'h100);
        rs1_choice = 3'b000; rs2_choice = 3'b010;
        rf_rdata1 = 32'h11; mem_alu_data = 32'h22;
        id_rs1_used = 1; id_rs2_used = 1;
        cycle("plain");
        check("plain_valid", 64'(ex_valid), 64'd1);
        check("plain_src1",  64'(ex_src1),  64'h11);
        check("plain_src2",  64'(ex_src2),  64'h22);

        // ---- all choice codes ----
        rf_rdata1 = 32'hA0; exu_fwd_data = 32'hA1; mem_alu_data = 32'hA2;
        mem_load_data = 32'hA3; wb_data = 32'hA4; rf_rdata2 = 32'h77;
        exu_mem_ren = 0; rs2_choice = 3'b000;
        for (int i = 0; i < 8; i++) begin
            drive_instr(32'h200 + 32'(i * 4));
            rs1_choice = tbl[i].c1;
            cycle("sweep");
            check($sformatf("sweep_code%0d", i), 64'(ex_src1), 64'(tbl[i].exp_src1));
        end

        // ---- load-use bubble then resolution ----
        drive_instr(32'h300);
        exu_mem_ren = 1; rs1_choice = 3'b001; id_rs1_used = 1;
        id_rs2_used = 0; rs2_choice = 3'b000;
        #1;
        check("luse_id_ready", 64'(id_ready), 64'd0);
        cycle("luse");
        check("luse_bubble", 64'(ex_valid), 64'd0);
        check("luse_cnt",    64'(luse_stall_cnt), 64'd1);
        exu_mem_ren = 0; rs1_choice = 3'b011; mem_load_data = 32'hDEAD;
        cycle("luse_res");
        check("luse_res_valid", 64'(ex_valid), 64'd1);
        check("luse_res_src1",  64'(ex_src1),  64'hDEAD);

        // ---- false stall: rs1 not used ----
        drive_instr(32'h340);
        exu_mem_ren = 1; rs1_choice = 3'b001; id_rs1_used = 0; id_rs2_used = 0;
        #1;
        check("nostall_id_ready", 64'(id_ready), 64'd1);
        cycle("nostall");
        check("nostall_valid", 64'(ex_valid), 64'd1);
        check("nostall_cnt",   64'(luse_stall_cnt), 64'd1);
        exu_mem_ren = 0;

        // ---- backpressure ----
        held_pc = ex_pc;
        ex_ready = 0;
        for (int i = 0; i < 3; i++) begin
            drive_instr(32'h500 + 32'(i));
            #1;
            check("bp_id_ready", 64'(id_ready), 64'd0);
            cycle("bp");
            check("bp_hold_pc", 64'(ex_pc), 64'(held_pc));
        end
        ex_ready = 1;
        drive_instr(32'h600);
        cycle("bp_release");
        check("bp_release_pc", 64'(ex_pc), 64'h600);

        // ---- flush with load_use ----
        cnt_before = luse_stall_cnt;
        drive_instr(32'h700);
        exu_mem_ren = 1; rs1_choice = 3'b001; id_rs1_used = 1; flush = 1;
        #1;
        check("flush_lu_id_ready", 64'(id_ready), 64'd0);
        cycle("flush_lu");
        check("flush_lu_valid", 64'(ex_valid), 64'd0);
        check("flush_lu_cnt",   64'(luse_stall_cnt), 64'(cnt_before));

        // ---- flush with fire ----
        drive_instr(32'h800);
        exu_mem_ren = 0; rs1_choice = 3'b000; flush = 1;
        cycle("flush_fire");
        check("flush_fire_valid", 64'(ex_valid), 64'd0);
        flush = 0;

        // ---- async reset mid-cycle ----
        drive_instr(32'h900);
        exu_mem_ren = 1; rs1_choice = 3'b001; id_rs1_used = 1;
        cycle("pre_rst_lu");
        exu_mem_ren = 0; rs1_choice = 3'b000;
        cycle("pre_rst_fire");
        #2;
        rst_n = 0;
        #1;
        check("async_rst_valid", 64'(ex_valid), 64'd0);
        check("async_rst_cnt",   64'(luse_stall_cnt), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        drive_instr(32'hA00);
        cycle("post_rst");
        check("post_rst_valid", 64'(ex_valid), 64'd1);

        // ---- randomized against the model ----
        for (int i = 0; i < 400; i++) begin
            drive_rand();
            cycle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        bad++;
        $display("FAIL timeout act=running exp=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
